// File: rtl/md_pos_pkg.sv
// Shared types for the cell position readers: sweep FSM states and the
// packed {posz, posy, posx} record layout.
package md_pos_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CNT_REQ,
      CNT_WAIT,
      STREAM,
      DRAIN,
      FINISH
   } reader_state_e;

   localparam int POS_W   = 32;
   localparam int POSX_LO = 0;
   localparam int POSX_HI = 31;
   localparam int POSY_LO = 32;
   localparam int POSY_HI = 63;
   localparam int POSZ_LO = 64;
   localparam int POSZ_HI = 95;

   function automatic logic [3*POS_W-1:0] pack_pos(input logic [POS_W-1:0] x,
                                                   input logic [POS_W-1:0] y,
                                                   input logic [POS_W-1:0] z);
      return {z, y, x};
   endfunction

endpackage

// File: rtl/pos_reader_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible
// on rd_data. A write and a pop may share a cycle even when full.
module pos_reader_fifo
   import md_pos_pkg::*;
#(
   parameter int WIDTH = 105,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_wr, do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (do_wr && (wr_ptr_q == PTR_W'(i))) ? wr_data : mem_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/pos_cell_reader.sv
// Sweeps one cell position memory: reads the particle count at address 0,
// then streams records 1..N through a credit-protected FWFT buffer.
module pos_cell_reader
   import md_pos_pkg::*;
#(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] particle_count,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pos,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last
);
   localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W   = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
   localparam int WAIT_W  = $clog2(READ_LATENCY + 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

   reader_state_e         state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d;
   logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [ADDR_WIDTH-1:0]   pipe_addr_q [READ_LATENCY];
   logic [ADDR_WIDTH-1:0]   pipe_addr_d [READ_LATENCY];

   logic [ADDR_WIDTH-1:0] raw_n, clamped_n, tail_addr;
   logic [OCC_W-1:0]      inflight, occupancy;
   logic                  data_rd, credit_ok, drain_done;
   logic                  fifo_wr, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [ENTRY_W-1:0]    fifo_wdata, fifo_rdata;

   assign raw_n     = rd_data[ADDR_WIDTH-1:0];
   assign clamped_n = (raw_n > MAX_N) ? MAX_N : raw_n;
   // Address 0 is the count word; only record reads enter the tracking pipe.
   assign data_rd   = rd_en_q && (rd_addr_q != '0);
   assign tail_addr = pipe_addr_q[READ_LATENCY-1];

   always_comb begin
      pipe_vld_d[0]  = data_rd;
      pipe_addr_d[0] = rd_addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_addr_d[i] = pipe_addr_q[i-1];
      end
   end

   always_comb begin
      inflight = OCC_W'(data_rd);
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OCC_W'(pipe_vld_q[i]);
   end

   // A pop this cycle frees a slot in time for a read issued next cycle, which
   // is what lets a FIFO of READ_LATENCY+2 entries sustain one record per cycle.
   assign occupancy  = inflight + OCC_W'(fifo_count) - OCC_W'(fifo_pop);
   assign credit_ok  = (occupancy < OCC_W'(FIFO_DEPTH)) && !(fifo_full && !fifo_pop);
   assign drain_done = (inflight == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

   always_comb begin
      state_d    = state_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      n_d        = n_q;
      addr_cnt_d = addr_cnt_q;
      wait_d     = wait_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CNT_REQ;
               rd_en_d    = 1'b1;
               rd_addr_d  = '0;
               addr_cnt_d = '0;
            end
         end
         CNT_REQ: begin
            state_d = CNT_WAIT;
            wait_d  = '0;
         end
         CNT_WAIT: begin
            if (wait_q == WAIT_W'(READ_LATENCY - 1)) begin
               n_d = clamped_n;
               if (clamped_n == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d    = STREAM;
                  rd_en_d    = 1'b1;
                  rd_addr_d  = ADDR_WIDTH'(1);
                  addr_cnt_d = ADDR_WIDTH'(1);
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         STREAM: begin
            if (addr_cnt_q == n_q) begin
               state_d = DRAIN;
            end else if (credit_ok) begin
               rd_en_d    = 1'b1;
               rd_addr_d  = addr_cnt_q + 1'b1;
               addr_cnt_d = addr_cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_done) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         n_q        <= '0;
         addr_cnt_q <= '0;
         wait_q     <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_addr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         n_q         <= n_d;
         addr_cnt_q  <= addr_cnt_d;
         wait_q      <= wait_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_addr_q <= pipe_addr_d;
      end
   end

   assign fifo_wr    = pipe_vld_q[READ_LATENCY-1];
   assign fifo_wdata = {(tail_addr == n_q), tail_addr, rd_data};
   assign fifo_pop   = out_valid && out_ready;

   pos_reader_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid      = !fifo_empty;
   assign out_last       = fifo_rdata[ENTRY_W-1];
   assign out_index      = fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
   assign out_pos        = fifo_rdata[DATA_WIDTH-1:0];
   assign busy           = (state_q == CNT_REQ) || (state_q == CNT_WAIT) ||
                           (state_q == STREAM)  || (state_q == DRAIN);
   assign done           = (state_q == FINISH);
   assign rd_en          = rd_en_q;
   assign rd_addr        = rd_addr_q;
   assign particle_count = n_q;

endmodule

// File: tb/tb_pos_cell_reader.sv
// Directed bench for pos_cell_reader with a 2-cycle-latency memory model.
module tb_pos_cell_reader;
   localparam int DW = 96;
   localparam int AW = 8;
   localparam int PN = 220;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done;
   logic [AW-1:0] particle_count, rd_addr, out_index;
   logic          rd_en, out_valid, out_ready, out_last;
   logic [DW-1:0] rd_data, out_pos;

   logic [DW-1:0] mem_img [PN];
   logic [DW-1:0] q1, q2;

   int checks = 0;
   int errors = 0;
   int dc, got, dn, pk, vc;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      q1 <= rd_en ? mem_img[rd_addr] : '0;
      q2 <= q1;
   end
   assign rd_data = q2;

   pos_cell_reader #(
      .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW),
      .READ_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .particle_count(particle_count), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pos(out_pos), .out_index(out_index), .out_last(out_last)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the start cycle; mode 0 ready high, 1 ready low in cycles 8..15, 2 random.
   task automatic run_sweep(input int n, input int mode, input bit restart_pulse, input int budget,
                            output int done_cyc, output int nrec, output int done_cnt,
                            output int peak, output int valid_cycles);
      int exp_idx, issued, popped;
      exp_idx = 1; issued = 0; popped = 0;
      done_cyc = -1; nrec = 0; done_cnt = 0; peak = 0; valid_cycles = 0;
      start = 1'b1;
      out_ready = (mode != 1);
      tick();
      for (int c = 1; c <= budget; c++) begin
         start = restart_pulse && (c == 5);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(c >= 8 && c <= 15);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (c == 1) begin
            check("cnt_req_rd_en", rd_en, 1);
            check("cnt_req_rd_addr", rd_addr, 0);
            check("cnt_req_busy", busy, 1);
         end
         if (rd_en && rd_addr != '0) issued++;
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            check("rec_index", out_index, exp_idx);
            check("rec_pos", out_pos, mem_img[exp_idx]);
            check("rec_last", out_last, (exp_idx == n));
            if (mode == 0) check("rec_cycle", c, 6 + exp_idx);
            exp_idx++; nrec++; popped++;
         end
         if (issued - popped > peak) peak = issued - popped;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               check("busy_low_at_done", busy, 0);
            end
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         tick();
      end
      start = 1'b0;
      check("done_pulses", done_cnt, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      for (int a = 1; a < PN; a++)
         mem_img[a] = md_pos_pkg::pack_pos(32'h1000_0000 + a, 32'h2000_0000 + a, 32'h3000_0000 + a);
      mem_img[0] = '0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pos", out_pos, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_last", out_last, 0);
      check("rst_particle_count", particle_count, 0);
      rst = 1'b0;
      tick();

      mem_img[0] = 96'd3;
      run_sweep(3, 0, 1'b0, 100, dc, got, dn, pk, vc);
      check("basic_done_cycle", dc, 10);
      check("basic_records", got, 3);
      check("basic_count", particle_count, 3);
      $display("basic sweep N=3: done cycle %0d, records %0d", dc, got);

      mem_img[0] = 96'd0;
      run_sweep(0, 0, 1'b0, 50, dc, got, dn, pk, vc);
      check("empty_done_cycle", dc, 4);
      check("empty_valid_cycles", vc, 0);
      check("empty_data_reads", pk, 0);
      check("empty_count", particle_count, 0);
      $display("empty cell: done cycle %0d, valid cycles %0d", dc, vc);

      mem_img[0] = 96'd8;
      run_sweep(8, 1, 1'b0, 200, dc, got, dn, pk, vc);
      check("bp_records", got, 8);
      check("bp_peak_outstanding", pk, 4);
      check("bp_done_cycle", dc, 23);
      $display("backpressure N=8: records %0d, peak outstanding %0d, done cycle %0d", got, pk, dc);

      for (int a = 1; a < PN; a++) mem_img[a] = {$urandom, $urandom, $urandom};
      mem_img[0] = 96'd219;
      run_sweep(219, 2, 1'b0, 3000, dc, got, dn, pk, vc);
      check("rand_records", got, 219);
      check("rand_peak_bound", (pk <= 4), 1);
      $display("random ready N=219: records %0d, peak outstanding %0d", got, pk);

      mem_img[0] = 96'd250;
      run_sweep(219, 0, 1'b0, 400, dc, got, dn, pk, vc);
      check("clamp_count", particle_count, 219);
      check("clamp_records", got, 219);
      check("clamp_done_cycle", dc, 226);
      $display("clamp count 250: particle_count %0d, records %0d", particle_count, got);

      mem_img[0] = 96'd4;
      run_sweep(4, 0, 1'b1, 100, dc, got, dn, pk, vc);
      check("restart_records", got, 4);
      check("restart_done_cycle", dc, 11);
      check("restart_idle_after", busy, 0);
      $display("ignored start N=4: records %0d, done pulses %0d", got, dn);

      mem_img[0] = 96'd8;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("midrst_rec5_index", out_index, 5);
      check("midrst_rec5_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_pos", out_pos, 0);
      check("midrst_out_index", out_index, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_rd_en", rd_en, 0);
      check("midrst_rd_addr", rd_addr, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_count", particle_count, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      mem_img[0] = 96'd2;
      run_sweep(2, 0, 1'b0, 50, dc, got, dn, pk, vc);
      check("post_rst_records", got, 2);
      check("post_rst_done_cycle", dc, 9);
      $display("post-reset sweep N=2: records %0d, done cycle %0d", got, dc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
